div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 integer divider for DIV/DIVU in the execute stage, beside the combinational ALU.
- Produces a 64-bit {remainder, quotient} word in the same format as the HI/LO register: hi = remainder, lo = quotient.
- Its result goes into the HI/LO write path.
- Asserts stall to freeze the pipeline while a division is in flight.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.

Ports:
- clk  in  1  clock, all state on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- start  in  1  request a division; sampled only in IDLE.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- a  in  WIDTH  dividend; sampled with start.
- b  in  WIDTH  divisor; sampled with start.
- cancel  in  1  flush (exception or branch squash); aborts any operation.
- stall  out  1  hold the pipeline.
- ready  out  1  one-cycle pulse: result valid this cycle.
- result  out  2*WIDTH  {remainder, quotient}; held stable until the next accepted start.

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE, counter=0, result=0, ready=0.
  - stall=0 unless start is high (stall is combinational).
  - Reset mid-operation discards all work; no ready is produced.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE, when start=1 and cancel=0:
  - Latch |a| and |b|: absolute value if signed_div, else raw.
  - Latch neg_q = signed_div & (a[31]^b[31]) and neg_r = signed_div & a[31].
  - If b==0: next state DONE, with result preset to {a, 32'hFFFFFFFF}.
  - Else: next state BUSY, counter=0, partial remainder=0, shift register=|a|.
- BUSY, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - If rem >= |b|: rem -= |b| and set the quotient LSB.
  - counter increments; after the step with counter==31, next state DONE.
  - Sign fixup is registered on the transition to DONE: negate q if neg_q, negate r if neg_r.
- DONE:
  - ready=1 for exactly this cycle; result valid.
  - Next state IDLE unconditionally; a start in DONE is ignored.
- Latency, start accepted at cycle T:
  - Normal case: BUSY in T+1..T+32, ready at T+33.
  - Divide by zero: ready at T+1.
- stall = (state==IDLE & start & ~cancel) | state==BUSY.
  - stall is 0 in DONE, so the pipeline consumes the result that cycle.
- start is ignored in BUSY and DONE; operands may change freely after acceptance.
- cancel has priority in every state:
  - Next state IDLE; ready is suppressed, including in DONE.
  - result keeps its previous value.
  - cancel and start in the same IDLE cycle: start is not accepted.
- Arithmetic:
  - Magnitudes are WIDTH-bit unsigned, so |0x80000000| = 0x80000000.
  - Signed 0x80000000 / -1 gives q=0x80000000, r=0 (wraps; no overflow flag).
  - Remainder takes the sign of the dividend (truncating division).

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, an accepted start with b!=0 and |a| < |b| goes directly to DONE at T+1 with result {a, 0}, i.e. r=a with its sign preserved and q=0. The full path is skipped.
- Undefined: every nonzero-divisor operation takes the full 33 cycles to ready.
- Results are bit-identical either way; only latency differs.

Decomposition:
- Shared defines header (same include as the ALU control codes):
  - DIV state encodings.
  - WIDTH default.
  - Divide-by-zero quotient constant 32'hFFFFFFFF.
  - ALU_DIV / ALU_DIVU control codes, which the decoder uses to drive start/signed_div.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: {rem, quo} and divisor.
  - Outputs: next {rem, quo}.
- div_unit keeps the FSM, counter, operand latches and sign fixup.

Test Plan:
- DIVU a=100, b=7 at T -> stall high T..T+32; ready only at T+33; result=64'h00000002_0000000E.
- DIV a=0xFFFFFFF9 (-7), b=2 -> result=64'hFFFFFFFF_FFFFFFFD (r=-1, q=-3).
- DIV a=0x80000000, b=0xFFFFFFFF -> result=64'h00000000_80000000 at T+33.
- DIVU a=5, b=0 -> ready at T+1; result=64'h00000005_FFFFFFFF.
- Cancel and reset mid-operation:
  - Start 20/4, assert cancel at T+10: no ready pulse; stall low from T+11.
  - New DIVU 20/4 started at T+12: ready at T+45, result=64'h00000000_00000005.
  - resetn low at T+5: all outputs 0 immediately.
- With DIV_EARLY_OUT_EN: DIVU 3/10 -> ready at T+1, result=64'h00000003_00000000. Without the macro: ready at T+33 with the same result.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared divider/ALU definitions: FSM state encodings, default operand width,
// divide-by-zero quotient and the ALU control codes that steer the divider.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLT  = 4'h5,
        ALU_SLTU = 4'h6,
        ALU_DIV  = 4'h7,
        ALU_DIVU = 4'h8
    } alu_op_e;

    // Decoder helper: returns {start, signed_div} for a given ALU control code.
    function automatic logic [1:0] div_ctrl(alu_op_e op);
        case (op)
            ALU_DIV:  return 2'b11;
            ALU_DIVU: return 2'b10;
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem, quo} left, subtract the divisor
// from the remainder when it fits and record the quotient bit.
module div_step
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // The shifted remainder can reach WIDTH+1 bits; diff[WIDTH] is then the borrow.
    assign rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    assign diff   = rem_sh - {1'b0, divisor_i};

    assign acc_o = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0}
                               : {diff[WIDTH-1:0],   acc_i[WIDTH-2:0], 1'b1};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 DIV/DIVU unit producing {remainder, quotient} for HI/LO.
// Define DIV_EARLY_OUT_EN to finish in one cycle when |a| < |b|.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cancel,
    output logic               stall,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int               CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ZERO_DIV_Q = {WIDTH{DIV_BY_ZERO_Q[0]}};

    div_state_e         state_q;
    logic [CNT_W-1:0]   count_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   divisor_q;
    logic               neg_quo_q;
    logic               neg_rem_q;
    logic [2*WIDTH-1:0] result_q;

    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               accept;
    logic               early_out;

    // Magnitudes stay WIDTH bits wide, so the most negative value maps onto itself.
    assign mag_a  = (signed_div && a[WIDTH-1]) ? -a : a;
    assign mag_b  = (signed_div && b[WIDTH-1]) ? -b : b;
    assign accept = (state_q == DIV_IDLE) && start && !cancel;

`ifdef DIV_EARLY_OUT_EN
    assign early_out = (mag_a < mag_b);
`else
    assign early_out = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .acc_i     (acc_q),
        .divisor_i (divisor_q),
        .acc_o     (acc_step)
    );

    assign quo_fix = neg_quo_q ? -acc_step[WIDTH-1:0]       : acc_step[WIDTH-1:0];
    assign rem_fix = neg_rem_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: datapath registers are reset too, so result reads 0 out of reset
        // rather than whatever power-up value the flops hold.
        if (!resetn) begin
            state_q   <= DIV_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            divisor_q <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else if (cancel) begin
            state_q <= DIV_IDLE;
        end else begin
            // NOTE: non-blocking assignments everywhere here; every register sees the
            // pre-edge values of the others, which the step datapath relies on.
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        divisor_q <= mag_b;
                        neg_quo_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_rem_q <= signed_div & a[WIDTH-1];
                        count_q   <= '0;
                        acc_q     <= {{WIDTH{1'b0}}, mag_a};
                        if (b == '0) begin
                            state_q  <= DIV_DONE;
                            result_q <= {a, ZERO_DIV_Q};
                        end else if (early_out) begin
                            state_q  <= DIV_DONE;
                            result_q <= {a, {WIDTH{1'b0}}};
                        end else begin
                            state_q <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    acc_q   <= acc_step;
                    count_q <= count_q + CNT_W'(1);
                    if (count_q == LAST_STEP) begin
                        state_q  <= DIV_DONE;
                        result_q <= {rem_fix, quo_fix};
                    end
                end
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

    assign stall  = accept || (state_q == DIV_BUSY);
    assign ready  = (state_q == DIV_DONE) && !cancel;
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors with literal expectations plus
// randomized start/cancel traffic checked every cycle against an arithmetic model.
module tb_div_unit;

    localparam int W = 32;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic           clk        = 1'b0;
    logic           resetn     = 1'b1;
    logic           start      = 1'b0;
    logic           signed_div = 1'b0;
    logic           cancel     = 1'b0;
    logic [W-1:0]   a          = '0;
    logic [W-1:0]   b          = '0;
    logic           stall;
    logic           ready;
    logic [2*W-1:0] result;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Transaction-level model of what the outputs must show.
    bit          pending    = 1'b0;
    int          remaining  = 0;
    logic [63:0] pend_res   = '0;
    logic [63:0] result_cur = '0;

    div_unit #(.WIDTH(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .a          (a),
        .b          (b),
        .cancel     (cancel),
        .stall      (stall),
        .ready      (ready),
        .result     (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_div(logic [31:0] x, logic [31:0] y, bit sgn);
        longint sx, sy, q, r;
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (sgn) begin
            sx = longint'(signed'(x));
            sy = longint'(signed'(y));
        end else begin
            sx = longint'({32'b0, x});
            sy = longint'({32'b0, y});
        end
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int model_latency(logic [31:0] x, logic [31:0] y, bit sgn);
        logic [31:0] mx, my;
        mx = (sgn && x[31]) ? -x : x;
        my = (sgn && y[31]) ? -y : y;
        if (y == 0 || (EARLY && mx < my)) return 1;
        return 33;
    endfunction

    // Compare process: check outputs mid-cycle, then advance the model with the
    // inputs the DUT will sample at the next rising edge.
    always @(negedge clk) begin
        logic exp_ready, exp_stall;
        if (!resetn) begin
            pending    = 1'b0;
            result_cur = '0;
        end else if (pending && remaining == 0) begin
            result_cur = pend_res;
        end
        exp_ready = resetn && pending && remaining == 0 && !cancel;
        exp_stall = pending ? (remaining != 0) : (start && !cancel);
        check("stall",  64'(stall),  64'(exp_stall));
        check("ready",  64'(ready),  64'(exp_ready));
        check("result", result, result_cur);
        if (resetn) begin
            if (pending) begin
                if (cancel || remaining == 0) pending = 1'b0;
                else remaining--;
            end else if (start && !cancel) begin
                pending   = 1'b1;
                remaining = model_latency(a, b, signed_div) - 1;
                pend_res  = model_div(a, b, signed_div);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 15));
            4:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic scramble();
        a          = $urandom;
        b          = $urandom;
        signed_div = 1'($urandom_range(0, 1));
    endtask

    // Issue one division from IDLE and wait (bounded) for its ready pulse.
    task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                          input bit sgn, input logic [63:0] exp_res, input int exp_lat);
        int t0;
        int lat = 0;
        start      = 1'b1;
        a          = av;
        b          = bv;
        signed_div = sgn;
        t0         = cyc;
        next_cycle();
        start = 1'b0;
        scramble();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin
                lat = cyc - t0;
                break;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
        check({name, "_result"}, result, exp_res);
        next_cycle();
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        bit          sgn;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int t0;
        vecs[0]  = '{"divu_100_7",   32'd100,       32'd7,         1'b0, 64'h00000002_0000000E, 33};
        vecs[1]  = '{"div_m7_2",     32'hFFFFFFF9,  32'd2,         1'b1, 64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2]  = '{"div_min_m1",   32'h80000000,  32'hFFFFFFFF,  1'b1, 64'h00000000_80000000, 33};
        vecs[3]  = '{"divu_5_0",     32'd5,         32'd0,         1'b0, 64'h00000005_FFFFFFFF, 1};
        vecs[4]  = '{"div_m5_0",     32'hFFFFFFFB,  32'd0,         1'b1, 64'hFFFFFFFB_FFFFFFFF, 1};
        vecs[5]  = '{"div_7_m2",     32'd7,         32'hFFFFFFFE,  1'b1, 64'h00000001_FFFFFFFD, 33};
        vecs[6]  = '{"divu_3_10",    32'd3,         32'd10,        1'b0, 64'h00000003_00000000, EARLY ? 1 : 33};
        vecs[7]  = '{"div_m3_10",    32'hFFFFFFFD,  32'd10,        1'b1, 64'hFFFFFFFD_00000000, EARLY ? 1 : 33};
        vecs[8]  = '{"divu_max_1",   32'hFFFFFFFF,  32'd1,         1'b0, 64'h00000000_FFFFFFFF, 33};
        vecs[9]  = '{"divu_min_max", 32'h80000000,  32'hFFFFFFFF,  1'b0, 64'h80000000_00000000, EARLY ? 1 : 33};
        vecs[10] = '{"div_min_min",  32'h80000000,  32'h80000000,  1'b1, 64'h00000000_00000001, 33};

        #1 resetn = 1'b0;
        #1;
        check("reset_stall",  64'(stall), 64'(0));
        check("reset_ready",  64'(ready), 64'(0));
        check("reset_result", result, 64'h0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        next_cycle();

        foreach (vecs[i]) begin
            check({vecs[i].name, "_model"}, model_div(vecs[i].a, vecs[i].b, vecs[i].sgn), vecs[i].res);
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].res, vecs[i].lat);
        end

        // Cancel mid-operation, then a fresh division right after.
        t0 = cyc;
        start = 1'b1; a = 32'd20; b = 32'd4; signed_div = 1'b0;
        next_cycle();
        start = 1'b0;
        scramble();
        while (cyc < t0 + 10) next_cycle();
        cancel = 1'b1;
        next_cycle();
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_stall", 64'(stall), 64'(0));
        check("cancel_ready", 64'(ready), 64'(0));
        next_cycle();
        run_op("after_cancel", 32'd20, 32'd4, 1'b0, 64'h00000000_00000005, 33);

        // Start and cancel together in IDLE: not accepted.
        start = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd3;
        @(negedge clk);
        check("start_cancel_stall", 64'(stall), 64'(0));
        next_cycle();
        start = 1'b0; cancel = 1'b0;
        repeat (3) next_cycle();

        // Asynchronous reset mid-operation.
        t0 = cyc;
        start = 1'b1; a = 32'd100; b = 32'd7; signed_div = 1'b0;
        next_cycle();
        start = 1'b0;
        while (cyc < t0 + 5) next_cycle();
        resetn = 1'b0;
        #1;
        check("midreset_stall",  64'(stall), 64'(0));
        check("midreset_ready",  64'(ready), 64'(0));
        check("midreset_result", result, 64'h0);
        next_cycle();
        resetn = 1'b1;
        repeat (40) next_cycle();

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 1500; i++) begin
            start      = ($urandom_range(0, 3) == 0);
            cancel     = ($urandom_range(0, 39) == 0);
            signed_div = 1'($urandom_range(0, 1));
            a          = pick();
            b          = pick();
            next_cycle();
        end
        start  = 1'b0;
        cancel = 1'b0;
        repeat (40) next_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
